// File: rtl/display_pkg.sv
// Shared types and width helpers for the multiplexed 7-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Width of the slot index; at least one bit.
    function automatic int unsigned slot_w(input int unsigned num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

    // Width of the in-slot cycle counter; at least one bit.
    function automatic int unsigned cnt_w(input int unsigned refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

endpackage

// File: rtl/display_mux_ctrl_timer.sv
// Per-slot cycle counter with blanking and slot-end flags.
module refresh_timer
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 20000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_slot_end_c,
    output logic o_blank_next_c
);

    localparam int unsigned CNT_W = cnt_w(REFRESH_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_slot_end;
    logic             w_blank_next;

    // Last cycle of the slot, and whether the following cycle still falls in blanking.
    always_comb begin
        w_slot_end   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
        w_blank_next = ((32'(r_cnt) + 32'd1) < 32'(BLANK_CYCLES));
    end

    // Counter runs 0..REFRESH_DIV-1 and wraps at slot end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_slot_end_c   = w_slot_end;
    assign o_blank_next_c = w_blank_next;

endmodule

// File: rtl/display_mux_ctrl.sv
// Scan controller: shares one segment decoder between digits, with blanking
// dead-time between slots and a per-frame snapshot of the digit bus.
module display_mux_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned REFRESH_DIV  = 20000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]            digit_en,
    input  logic                             hold,
    output logic [NIBBLE_W-1:0]              s_out,
    output logic [NUM_DIGITS-1:0]            an,
    output logic [slot_w(NUM_DIGITS)-1:0]    slot,
    output logic                             frame_tick
);

    localparam int unsigned SLOT_W = slot_w(NUM_DIGITS);
    localparam int unsigned DIG_W  = NIBBLE_W * NUM_DIGITS;

    scan_state_t            r_state;
    scan_state_t            w_state_nxt;
    logic [SLOT_W-1:0]      r_slot;
    logic [SLOT_W-1:0]      w_slot_nxt;
    logic [SLOT_W-1:0]      r_slot_out;
    logic [DIG_W-1:0]       r_shadow;
    logic [DIG_W-1:0]       w_shadow_nxt;
    logic [NIBBLE_W-1:0]    r_s_out;
    logic [NIBBLE_W-1:0]    w_s_out_nxt;
    logic [NUM_DIGITS-1:0]  r_an;
    logic [NUM_DIGITS-1:0]  w_an_nxt;
    logic                   r_tick;
    logic                   w_tick_nxt;
    logic                   w_slot_end;
    logic                   w_blank_next;
    logic [NIBBLE_W-1:0]    w_nibble;

    refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .i_clk          (clk),
        .i_rst_n        (reset),
        .o_slot_end_c   (w_slot_end),
        .o_blank_next_c (w_blank_next)
    );

    // Snapshot nibble belonging to the slot being scanned.
    assign w_nibble = r_shadow[{r_slot, 2'b00} +: NIBBLE_W];

    // Next-state and next-output logic for the scan sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_shadow_nxt = r_shadow;
        w_s_out_nxt  = r_s_out;
        w_an_nxt     = '1;
        w_tick_nxt   = 1'b0;

        case (r_state)
            LOAD: begin
                w_tick_nxt = 1'b1;
                if (hold) begin
                    w_s_out_nxt = r_shadow[NIBBLE_W-1:0];
                end else begin
                    w_shadow_nxt = digits;
                    w_s_out_nxt  = digits[NIBBLE_W-1:0];
                end
            end
            BLANK: begin
                w_s_out_nxt = w_nibble;
            end
            DRIVE: begin
                w_an_nxt[r_slot] = ~digit_en[r_slot];
            end
            default: begin
                w_an_nxt = '1;
            end
        endcase

        if (w_slot_end) begin
            if (r_slot == SLOT_W'(NUM_DIGITS - 1)) begin
                w_slot_nxt  = '0;
                w_state_nxt = LOAD;
            end else begin
                w_slot_nxt  = r_slot + SLOT_W'(1);
                w_state_nxt = BLANK;
            end
        end else if (w_blank_next) begin
            w_state_nxt = BLANK;
        end else begin
            w_state_nxt = DRIVE;
        end
    end

    // Scan state, snapshot and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= LOAD;
            r_slot     <= '0;
            r_slot_out <= '0;
            r_shadow   <= '0;
            r_s_out    <= '0;
            r_an       <= '1;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_slot_out <= r_slot;
            r_shadow   <= w_shadow_nxt;
            r_s_out    <= w_s_out_nxt;
            r_an       <= w_an_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign s_out      = r_s_out;
    assign an         = r_an;
    assign slot       = r_slot_out;
    assign frame_tick = r_tick;

endmodule
